uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Memory-mapped I/O controller between the RISC-V core's memory stage and the UART RX/TX ready/valid ports. It decodes accesses in the 0x8000_00xx window and sequences the UART handshakes. It buffers one transmit byte and keeps the cycle and retired-instruction performance counters. Load data returns one cycle after the access, matching the data-memory read latency, so the core's writeback mux treats MMIO like any memory source.

## Interface
Parameters:
- `CNT_W`, 32: width of the cycle and instruction counters; must be ≤ 32.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `mem_addr`  in  32  byte address from the memory stage.
- `mem_rd`  in  1  load in the memory stage this cycle.
- `mem_wr`  in  1  store in the memory stage this cycle; never asserted together with `mem_rd`.
- `mem_wdata`  in  32  store data; only bits [7:0] are used for TX.
- `inst_valid`  in  1  one pulse per retired non-bubble instruction.
- `mmio_rdata`  out  32  registered load data, valid the cycle after `mem_rd`.
- `rx_data`  in  8  UART receiver byte.
- `rx_valid`  in  1  receiver has a byte.
- `rx_ready`  out  1  pop strobe to the receiver.
- `tx_data`  out  8  byte to the UART transmitter.
- `tx_valid`  out  1  transmit byte pending.
- `tx_ready`  in  1  transmitter accepts a byte.

## Operation
- Hit: `mem_addr[31:28]==4'h8`. Offset is `mem_addr[7:0]`. Non-hit accesses are ignored entirely.
- Load 0x00 (status) returns `{30'b0, rx_valid, ~tx_full}`.
- Load 0x04 returns `{24'b0, rx_data}`. `rx_ready` = `mem_rd & hit & off==0x04 & rx_valid`, combinational, one cycle per load. A load at 0x04 with `rx_valid`=0 returns the current `rx_data` with no pop.
- Load 0x10 returns the cycle count. Load 0x14 returns the instruction count. Both are zero-extended to 32 bits.
- Load to any other offset returns 0.
- Store 0x08 writes the TX byte into the one-entry holding register `tx_buf`/`tx_full`.
  - Accepted when `tx_full`=0, or when `tx_valid & tx_ready` completes in the same cycle.
  - Otherwise the byte is dropped. Software polls status bit0 before storing.
- Store 0x18 clears both counters. Stores to other offsets are ignored.
- `tx_valid` = `tx_full`; `tx_data` = `tx_buf`. `tx_full` clears on `tx_valid & tx_ready`, unless refilled that cycle.
- Cycle counter: +1 every cycle out of reset. Instruction counter: +1 when `inst_valid`. Both wrap modulo 2^CNT_W.
- If a clear (store 0x18) and an increment occur in the same cycle, the clear wins and the counter is 0 the next cycle.

## Timing
- Reset values: `mmio_rdata`=0, `tx_full`=0, `tx_valid`=0, `tx_data`=0, counters=0. `rx_ready`=0 while `rst`.
- Load latency is 1 cycle. `mmio_rdata` holds its value until the next load that hits the window.
- A counter read returns the value before that cycle's increment.
- Store to 0x08 in cycle N gives `tx_valid`=1 in cycle N+1. With `tx_ready` held high, back-to-back stores stream one byte per cycle.
- Status read in cycle N reflects `tx_full` and `rx_valid` sampled in cycle N.
- `rst` asserted mid-transmit drops a pending `tx_buf` byte; `tx_valid` is 0 the next cycle.

## Configuration
- `UART_MMIO_COUNTERS_EN` defined: both counters are built; offsets 0x10, 0x14 and 0x18 behave as described above.
- `UART_MMIO_COUNTERS_EN` undefined: no counter flops are built. Loads at 0x10 and 0x14 return 0, and stores to 0x18 are ignored. UART behaviour is unchanged.

## Structure
- Package `mmio_pkg`: `MMIO_BASE_NIBBLE`=4'h8, and the offsets `OFF_UART_CTRL`=0x00, `OFF_UART_RX`=0x04, `OFF_UART_TX`=0x08, `OFF_CYC_CNT`=0x10, `OFF_INST_CNT`=0x14, `OFF_CNT_RST`=0x18.
- Sub-module `mmio_counter`: parameter `CNT_W`, inputs `clk`, `rst`, `clr`, `inc`, output `count`. Instantiated twice under the macro.

## Test plan
- Reset, then a load at 0x8000_0000 → `mmio_rdata`=0x1 (TX empty, no RX) one cycle later; `tx_valid`=0.
- `rx_valid`=1, `rx_data`=0x5A, load at 0x8000_0004 → `rx_ready` pulses for exactly 1 cycle, and `mmio_rdata`=0x0000_005A the next cycle.
- `tx_ready`=0, store 0x41 then 0x42 to 0x8000_0008 → `tx_data`=0x41 with `tx_valid` held, and 0x42 dropped. Raise `tx_ready` for 1 cycle → `tx_valid`=0; status bit0=1.
- `tx_ready`=1, stores in 3 consecutive cycles → `tx_data` sequence 0x01, 0x02, 0x03 on 3 consecutive cycles, with no drop.
- 100 cycles out of reset with 40 `inst_valid` pulses, then load 0x10 and 0x14 → 100 and 40. Store to 0x18 together with an `inst_valid` pulse → both counters read 0 then 1 on subsequent loads, per their increment rules.
- Preload the cycle counter to 0xFFFF_FFFF via a forced value, then run 1 cycle → reads 0 (wrap). With the macro undefined, load 0x10 → 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Address map shared by the UART MMIO controller and its sub-blocks.
package mmio_pkg;
   localparam logic [3:0] MMIO_BASE_NIBBLE = 4'h8;
   localparam logic [7:0] OFF_UART_CTRL    = 8'h00;
   localparam logic [7:0] OFF_UART_RX      = 8'h04;
   localparam logic [7:0] OFF_UART_TX      = 8'h08;
   localparam logic [7:0] OFF_CYC_CNT      = 8'h10;
   localparam logic [7:0] OFF_INST_CNT     = 8'h14;
   localparam logic [7:0] OFF_CNT_RST      = 8'h18;
endpackage

// File: rtl/mmio_counter.sv
// Wrapping performance counter; a clear beats an increment in the same cycle.
module mmio_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)      count_d = '0;
      else if (inc) count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/uart_mmio_ctrl.sv
// MMIO bridge between the core memory stage and the UART ready/valid ports.
// Define UART_MMIO_COUNTERS_EN to build the cycle/instruction counters.
module uart_mmio_ctrl
   import mmio_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_addr,
   input  logic        mem_rd,
   input  logic        mem_wr,
   input  logic [31:0] mem_wdata,
   input  logic        inst_valid,
   output logic [31:0] mmio_rdata,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready
);
   logic        hit, rd_hit, wr_hit;
   logic [7:0]  off;
   logic        tx_fire, tx_wr;
   logic        tx_full_q, tx_full_d;
   logic [7:0]  tx_buf_q, tx_buf_d;
   logic [31:0] mmio_rdata_q, mmio_rdata_d;
   logic [31:0] cyc_ext, inst_ext;
   logic        unused_ok;

   assign hit    = (mem_addr[31:28] == MMIO_BASE_NIBBLE);
   assign off    = mem_addr[7:0];
   assign rd_hit = mem_rd & hit;
   assign wr_hit = mem_wr & hit;

   assign rx_ready = rd_hit & (off == OFF_UART_RX) & rx_valid & ~rst;

   // A full buffer can still take a new byte in the cycle its old byte leaves.
   assign tx_fire = tx_full_q & tx_ready;
   assign tx_wr   = wr_hit & (off == OFF_UART_TX) & (~tx_full_q | tx_fire);

   always_comb begin
      tx_full_d = tx_full_q;
      tx_buf_d  = tx_buf_q;
      if (tx_wr) begin
         tx_full_d = 1'b1;
         tx_buf_d  = mem_wdata[7:0];
      end else if (tx_fire) begin
         tx_full_d = 1'b0;
      end
   end

`ifdef UART_MMIO_COUNTERS_EN
   logic             cnt_clr;
   logic [CNT_W-1:0] cyc_cnt, inst_cnt;

   assign cnt_clr = wr_hit & (off == OFF_CNT_RST);

   mmio_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(1'b1), .count(cyc_cnt)
   );
   mmio_counter #(.CNT_W(CNT_W)) u_inst_cnt (
      .clk(clk), .rst(rst), .clr(cnt_clr), .inc(inst_valid), .count(inst_cnt)
   );

   always_comb begin
      cyc_ext              = '0;
      inst_ext             = '0;
      cyc_ext[CNT_W-1:0]   = cyc_cnt;
      inst_ext[CNT_W-1:0]  = inst_cnt;
   end

   assign unused_ok = ^{mem_addr[27:8], mem_wdata[31:8]};
`else
   assign cyc_ext   = '0;
   assign inst_ext  = '0;
   assign unused_ok = ^{mem_addr[27:8], mem_wdata[31:8], inst_valid};
`endif

   // Load data holds until the next load that hits the window.
   always_comb begin
      mmio_rdata_d = mmio_rdata_q;
      if (rd_hit) begin
         case (off)
            OFF_UART_CTRL: mmio_rdata_d = {30'b0, rx_valid, ~tx_full_q};
            OFF_UART_RX:   mmio_rdata_d = {24'b0, rx_data};
            OFF_CYC_CNT:   mmio_rdata_d = cyc_ext;
            OFF_INST_CNT:  mmio_rdata_d = inst_ext;
            default:       mmio_rdata_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_full_q    <= 1'b0;
         tx_buf_q     <= '0;
         mmio_rdata_q <= '0;
      end else begin
         tx_full_q    <= tx_full_d;
         tx_buf_q     <= tx_buf_d;
         mmio_rdata_q <= mmio_rdata_d;
      end
   end

   assign tx_valid   = tx_full_q;
   assign tx_data    = tx_buf_q;
   assign mmio_rdata = mmio_rdata_q;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: load data and TX bytes go through expectation queues.
module tb_uart_mmio_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_wdata;
   logic        inst_valid;
   logic [31:0] mmio_rdata;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  txq[$];
   logic [31:0] e;
   logic [7:0]  eb;

`ifdef UART_MMIO_COUNTERS_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   uart_mmio_ctrl #(.CNT_W(32)) u_dut (
      .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .inst_valid(inst_valid), .mmio_rdata(mmio_rdata),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic idle();
      mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
   endtask

   // Drive a one-cycle load and queue the value expected on mmio_rdata afterwards.
   task automatic ld(input logic [31:0] a, input logic [31:0] exp_v);
      mem_addr = a; mem_rd = 1'b1;
      exp_q.push_back(exp_v);
      @(negedge clk);
      mem_rd = 1'b0;
   endtask

   task automatic st(input logic [31:0] a, input logic [31:0] d);
      mem_addr = a; mem_wdata = d; mem_wr = 1'b1;
      @(negedge clk);
      mem_wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle(); inst_valid = 1'b0; tx_ready = 1'b0; rx_data = 8'h11; rx_valid = 1'b1;
      rst = 1'b1;
      mem_addr = 32'h8000_0004; mem_rd = 1'b1;
      @(negedge clk); @(negedge clk);
      total_cnt++; if (rx_ready !== 1'b0) $display("FAIL rst_rx_ready got %b exp 0", rx_ready); else pass_cnt++;
      total_cnt++; if (mmio_rdata !== 32'h0) $display("FAIL rst_rdata got %h exp 0", mmio_rdata); else pass_cnt++;
      total_cnt++; if ({tx_valid, tx_data} !== 9'h0) $display("FAIL rst_tx got %b/%h exp 0/00", tx_valid, tx_data); else pass_cnt++;
      idle(); rx_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_status();
      ld(32'h8000_0000, 32'h1);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL status_idle got %h exp %h", mmio_rdata, e); else pass_cnt++;
      total_cnt++; if (tx_valid !== 1'b0) $display("FAIL status_txv got %b exp 0", tx_valid); else pass_cnt++;
      // non-hit load must leave mmio_rdata alone
      ld(32'h4000_0004, 32'h1);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL nonhit_hold got %h exp %h", mmio_rdata, e); else pass_cnt++;
      ld(32'h8000_000C, 32'h0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL other_off got %h exp %h", mmio_rdata, e); else pass_cnt++;
   endtask

   task automatic test_rx();
      rx_data = 8'h5A; rx_valid = 1'b1;
      mem_addr = 32'h8000_0004; mem_rd = 1'b1;
      exp_q.push_back(32'h0000_005A);
      #1;
      total_cnt++; if (rx_ready !== 1'b1) $display("FAIL rx_pop got %b exp 1", rx_ready); else pass_cnt++;
      @(negedge clk);
      mem_rd = 1'b0;
      #1;
      total_cnt++; if (rx_ready !== 1'b0) $display("FAIL rx_pop_len got %b exp 0", rx_ready); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL rx_data got %h exp %h", mmio_rdata, e); else pass_cnt++;
      @(negedge clk);
      rx_data = 8'h33; rx_valid = 1'b0;
      mem_addr = 32'h8000_0004; mem_rd = 1'b1;
      #1;
      total_cnt++; if (rx_ready !== 1'b0) $display("FAIL rx_nopop got %b exp 0", rx_ready); else pass_cnt++;
      @(negedge clk);
      mem_rd = 1'b0;
      exp_q.push_back(32'h33);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL rx_empty_data got %h exp %h", mmio_rdata, e); else pass_cnt++;
   endtask

   task automatic test_tx_hold();
      tx_ready = 1'b0;
      st(32'h8000_0008, 32'hFFFF_FF41);
      txq.push_back(8'h41);
      st(32'h8000_0008, 32'h42);
      eb = txq.pop_front();
      total_cnt++; if ({tx_valid, tx_data} !== {1'b1, eb}) $display("FAIL tx_hold got %b/%h exp 1/%h", tx_valid, tx_data, eb); else pass_cnt++;
      ld(32'h8000_0000, 32'h0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL status_full got %h exp %h", mmio_rdata, e); else pass_cnt++;
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      total_cnt++; if (tx_valid !== 1'b0) $display("FAIL tx_drain got %b exp 0", tx_valid); else pass_cnt++;
      ld(32'h8000_0000, 32'h1);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL status_drained got %h exp %h", mmio_rdata, e); else pass_cnt++;
      st(32'h0000_0008, 32'h99);
      total_cnt++; if (tx_valid !== 1'b0) $display("FAIL nonhit_store got %b exp 0", tx_valid); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      tx_ready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         txq.push_back(8'(i));
         st(32'h8000_0008, 32'(i));
         eb = txq.pop_front();
         total_cnt++;
         if ({tx_valid, tx_data} !== {1'b1, eb}) $display("FAIL b2b_byte%0d got %b/%h exp 1/%h", i, tx_valid, tx_data, eb);
         else pass_cnt++;
      end
      @(negedge clk);
      total_cnt++; if (tx_valid !== 1'b0) $display("FAIL b2b_end got %b exp 0", tx_valid); else pass_cnt++;
      tx_ready = 1'b0;
   endtask

   task automatic test_rst_mid_tx();
      tx_ready = 1'b0;
      st(32'h8000_0008, 32'h77);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++; if ({tx_valid, tx_data} !== 9'h0) $display("FAIL rst_mid_tx got %b/%h exp 0/00", tx_valid, tx_data); else pass_cnt++;
   endtask

   task automatic test_counters();
      do_reset();
      for (int i = 0; i < 100; i++) begin
         inst_valid = (i < 40);
         @(negedge clk);
      end
      inst_valid = 1'b0;
      ld(32'h8000_0010, CNT_EN ? 32'd100 : 32'd0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL cyc_cnt got %0d exp %0d", mmio_rdata, e); else pass_cnt++;
      ld(32'h8000_0014, CNT_EN ? 32'd40 : 32'd0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL inst_cnt got %0d exp %0d", mmio_rdata, e); else pass_cnt++;
      // clear collides with an instruction retire: the clear wins
      inst_valid = 1'b1;
      st(32'h8000_0018, 32'h0);
      ld(32'h8000_0010, 32'd0);
      inst_valid = 1'b0;
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL cyc_clr got %0d exp %0d", mmio_rdata, e); else pass_cnt++;
      ld(32'h8000_0014, CNT_EN ? 32'd1 : 32'd0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL inst_clr got %0d exp %0d", mmio_rdata, e); else pass_cnt++;
      ld(32'h8000_0010, CNT_EN ? 32'd2 : 32'd0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL cyc_after got %0d exp %0d", mmio_rdata, e); else pass_cnt++;
   endtask

`ifdef UART_MMIO_COUNTERS_EN
   task automatic test_wrap();
      force u_dut.u_cyc_cnt.count_q = '1;
      #1;
      release u_dut.u_cyc_cnt.count_q;
      ld(32'h8000_0010, 32'hFFFF_FFFF);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL wrap_pre got %h exp %h", mmio_rdata, e); else pass_cnt++;
      ld(32'h8000_0010, 32'h0);
      e = exp_q.pop_front();
      total_cnt++; if (mmio_rdata !== e) $display("FAIL wrap got %h exp %h", mmio_rdata, e); else pass_cnt++;
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_status();
      test_rx();
      test_tx_hold();
      test_back_to_back();
      test_rst_mid_tx();
      test_counters();
`ifdef UART_MMIO_COUNTERS_EN
      @(negedge clk);
      test_wrap();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
